adc_spi_reader: RTL

- SPI master that periodically reads one 12-bit conversion from the force-sensor ADC.
- ADC frame: 16 bits, 4 leading zeros, then 12 data bits MSB first. SCLK idles high; ADC drives data on falling edge; block samples on rising edge.
- Sits directly upstream of the USB-side SPI slave stage: data_out feeds its 12-bit data input, new_data feeds its load-strobe input.
- Single clock domain; all outputs registered.

---
 rtl/adc_spi_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/adc_spi_reader.sv
// SPI master that periodically reads one 12-bit word from the force-sensor ADC.
// 16-bit frame, SCLK idles high, data sampled on SCLK rising edges.
module adc_spi_reader #(
    parameter int CLK_DIV       = 2,
    parameter int CS_SETUP      = 2,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_miso,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic [11:0] data_out,
    output logic        new_data,
    output logic        frame_err,
    output logic        busy,
    output logic        overrun
);

    localparam int CMAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam int TW   = $clog2(SAMPLE_PERIOD);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [TW-1:0] TMR_LAST   = TW'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_cnt, bit_n;
    logic [15:0]   shift_q, shift_n;
    logic [TW-1:0] timer;
    logic          tick;

    logic          sclk_n, cs_n_n, new_n, err_n, busy_n, ovr_n;
    logic [11:0]   data_n;

    assign tick = enable && (timer == '0);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            timer <= '0;
        end else if (timer == TMR_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shift_n = shift_q;
        sclk_n  = adc_sclk;
        cs_n_n  = adc_cs_n;
        data_n  = data_out;
        err_n   = frame_err;
        new_n   = 1'b0;
        ovr_n   = tick && (state != IDLE);

        unique case (state)
            IDLE: begin
                sclk_n = 1'b1;
                cs_n_n = 1'b1;
                if (tick) begin
                    state_n = SETUP;
                    cs_n_n  = 1'b0;
                    cnt_n   = '0;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = SHIFT;
                    sclk_n  = 1'b0;
                    cnt_n   = '0;
                    bit_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != DIV_LAST) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    // sample on the rising edge, leave after the 16th high half
                    if (!adc_sclk) begin
                        sclk_n  = 1'b1;
                        shift_n = {shift_q[14:0], adc_miso};
                    end else if (bit_cnt == 4'd15) begin
                        state_n = HOLD;
                    end else begin
                        sclk_n = 1'b0;
                        bit_n  = bit_cnt + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (cnt != DIV_LAST) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    cs_n_n  = 1'b1;
                    data_n  = shift_q[11:0];
                    err_n   = |shift_q[15:12];
                    new_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            adc_sclk  <= 1'b1;
            adc_cs_n  <= 1'b1;
            data_out  <= '0;
            frame_err <= 1'b0;
            new_data  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_n;
            shift_q   <= shift_n;
            adc_sclk  <= sclk_n;
            adc_cs_n  <= cs_n_n;
            data_out  <= data_n;
            frame_err <= err_n;
            new_data  <= new_n;
            busy      <= busy_n;
            overrun   <= ovr_n;
        end
    end

endmodule
